ahb_bridge_arbiter: RTL and testbench

Round-robin AHB arbiter that shares the single AHB slave port of the AHB-APB bridge between up to four AHB masters. It sits between the masters and the bridge front end. It issues HGRANT and HMASTER, multiplexes the granted master's address/control onto the bridge, and multiplexes HWDATA using the data-phase owner. It also caps each master's tenure so one master cannot starve the others of APB bandwidth.

---
 rtl/ahb_bridge_arbiter_pkg.sv | 24 ++
 rtl/ahb_bridge_arbiter_if.sv | 35 +++
 rtl/ahb_bridge_arbiter_rr_picker.sv | 28 ++
 rtl/ahb_bridge_arbiter.sv | 125 ++++++++++++
 tb/tb_ahb_bridge_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_bridge_arbiter_pkg.sv
// Shared AHB types for the bridge arbiter slice.
// Transfer encodings, arbiter states, master index.
package ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    ST_PARK  = 2'b00,
    ST_OWN   = 2'b01,
    ST_DRAIN = 2'b10
  } arb_state_t;

  typedef logic [1:0] midx_t;

  function automatic logic is_active(htrans_t t);
    return (t == HT_NONSEQ) || (t == HT_SEQ);
  endfunction

endpackage

// File: rtl/ahb_bridge_arbiter_if.sv
// Master-side request/bus bundle and arbiter-side
// muxed bridge outputs.
interface ahb_bridge_arbiter_if #(
  parameter int NUM_M = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  logic [NUM_M-1:0]    HBUSREQ;
  logic [2*NUM_M-1:0]  M_HTRANS;
  logic [AW*NUM_M-1:0] M_HADDR;
  logic [NUM_M-1:0]    M_HWRITE;
  logic [DW*NUM_M-1:0] M_HWDATA;
  logic                HREADY;
  logic [NUM_M-1:0]    HGRANT;
  logic [1:0]          HMASTER;
  logic [1:0]          HTRANS;
  logic [AW-1:0]       HADDR;
  logic                HWRITE;
  logic [DW-1:0]       HWDATA;
  logic                VALID;

  modport master (
    output HBUSREQ, M_HTRANS, M_HADDR, M_HWRITE,
    output M_HWDATA, HREADY,
    input  HGRANT, HMASTER, HTRANS, HADDR,
    input  HWRITE, HWDATA, VALID
  );

  modport slave (
    input  HBUSREQ, M_HTRANS, M_HADDR, M_HWRITE,
    input  M_HWDATA, HREADY,
    output HGRANT, HMASTER, HTRANS, HADDR,
    output HWRITE, HWDATA, VALID
  );
endinterface

// File: rtl/ahb_bridge_arbiter_rr_picker.sv
// Round-robin pick: first requester after last,
// wrapping, so last itself is searched last.
module rr_picker
  import ahb_pkg::*;
#(
  parameter int NUM_M = 4
) (
  input  logic [NUM_M-1:0] req,
  input  midx_t            last,
  output midx_t            nxt,
  output logic             any
);
  int j;

  always_comb begin
    nxt = '0;
    any = 1'b0;
    j   = 0;
    // descending scan: nearest requester wins
    for (int k = NUM_M; k >= 1; k--) begin
      j = (int'(last) + k) % NUM_M;
      if (req[j]) begin
        nxt = midx_t'(j);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin AHB arbiter with tenure cap in front
// of the AHB-APB bridge slave port.
module ahb_bridge_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_M      = 4,
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int TENURE_MAX = 8
) (
  input logic HCLK,
  input logic HRESETn,
  ahb_bridge_arbiter_if.slave bus
);
  localparam logic [7:0] TEN = 8'(TENURE_MAX);
  localparam logic [NUM_M-1:0] GNT0 =
    {{(NUM_M-1){1'b0}}, 1'b1};

  arb_state_t       state;
  midx_t            hmaster;
  midx_t            last_owner;
  midx_t            data_owner;
  logic [NUM_M-1:0] grant;
  logic [7:0]       tenure;

  htrans_t          own_trans;
  logic [AW-1:0]    own_addr;
  logic             own_write;
  logic             own_req;
  logic             others;
  logic [DW-1:0]    wdata;
  logic [NUM_M-1:0] pick_oh;
  midx_t            pick;
  logic             any;
  logic             valid;
  logic [7:0]       tenure_nxt;
  logic             leave;
  logic             is_seq;
  logic             do_rearb;

  rr_picker #(.NUM_M(NUM_M)) u_pick (
    .req  (bus.HBUSREQ),
    .last (last_owner),
    .nxt  (pick),
    .any  (any)
  );

  always_comb begin
    own_trans = HT_IDLE;
    own_addr  = '0;
    own_write = 1'b0;
    own_req   = 1'b0;
    others    = 1'b0;
    wdata     = '0;
    pick_oh   = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (hmaster == midx_t'(i)) begin
        own_trans = htrans_t'(bus.M_HTRANS[2*i +: 2]);
        own_addr  = bus.M_HADDR[AW*i +: AW];
        own_write = bus.M_HWRITE[i];
        own_req   = bus.HBUSREQ[i];
      end else begin
        others = others | bus.HBUSREQ[i];
      end
      if (data_owner == midx_t'(i))
        wdata = bus.M_HWDATA[DW*i +: DW];
      pick_oh[i] = (pick == midx_t'(i));
    end
  end

  assign valid  = bus.HREADY & is_active(own_trans);
  assign is_seq = (own_trans == HT_SEQ);
  // cap judged on the count including this beat
  assign tenure_nxt =
    (valid && tenure != TEN) ? tenure + 8'd1 : tenure;
  assign leave = !own_req ||
    ((tenure_nxt == TEN) && others);

  always_comb begin
    unique case (state)
      ST_PARK:  do_rearb = 1'b1;
      ST_OWN:   do_rearb = leave && !is_seq;
      ST_DRAIN: do_rearb = !is_seq;
      default:  do_rearb = 1'b1;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      state      <= ST_PARK;
      hmaster    <= '0;
      grant      <= GNT0;
      last_owner <= midx_t'(NUM_M - 1);
      data_owner <= '0;
      tenure     <= '0;
    end else if (bus.HREADY) begin
      data_owner <= hmaster;
      if (do_rearb) begin
        tenure <= '0;
        if (any) begin
          state      <= ST_OWN;
          hmaster    <= pick;
          last_owner <= pick;
          grant      <= pick_oh;
        end else begin
          state   <= ST_PARK;
          hmaster <= '0;
          grant   <= GNT0;
        end
      end else begin
        tenure <= tenure_nxt;
        if (state == ST_OWN && leave)
          state <= ST_DRAIN;
      end
    end
  end

  assign bus.HGRANT  = grant;
  assign bus.HMASTER = hmaster;
  assign bus.HTRANS  = own_trans;
  assign bus.HADDR   = own_addr;
  assign bus.HWRITE  = own_write;
  assign bus.HWDATA  = wdata;
  assign bus.VALID   = valid;
endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Scoreboard bench: driver pushes model expectations,
// negedge monitor pops and compares.
module tb_ahb_bridge_arbiter;
  import ahb_pkg::*;

  localparam int NM  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TEN = 8;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  ahb_bridge_arbiter_if #(.NUM_M(NM), .AW(AW), .DW(DW)) bus();

  ahb_bridge_arbiter #(
    .NUM_M(NM), .AW(AW), .DW(DW), .TENURE_MAX(TEN)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic [3:0]  gnt;
    logic [1:0]  hm;
    logic        vld;
    logic [1:0]  tr;
    logic [31:0] ad;
    logic        wr;
    logic [31:0] wd;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  bit          req[NM];
  logic [1:0]  intent[NM];
  logic [1:0]  rtr[NM];
  logic [1:0]  drv[NM];
  logic [31:0] addr[NM];
  logic [31:0] wdat[NM];
  bit          wr[NM];
  logic [1:0]  bq[$];
  int          bm = 1;
  bit          rnd_mode = 0;
  bit          hready = 1;

  // reference: owner (-1 = parked), accepted count, drain flag
  int m_own, m_last, m_cnt, m_down;
  bit m_drain;

  bit aud_on = 0;
  int aud_cur, aud_cnt;
  int aud_m[$];
  int aud_n[$];

  function automatic int msel();
    return (m_own < 0) ? 0 : m_own;
  endfunction

  function automatic int rr_next();
    for (int k = 1; k <= NM; k++) begin
      int j = (m_last + k) % NM;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [1:0] intent_of(int i);
    if (rnd_mode) return rtr[i];
    if (i == bm && bq.size() != 0) return bq[0];
    return intent[i];
  endfunction

  task automatic model_reset();
    m_own = -1; m_last = NM - 1; m_cnt = 0;
    m_down = 0; m_drain = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < NM; i++) begin
      drv[i] = (m_own == i) ? intent_of(i) : HT_IDLE;
      bus.HBUSREQ[i]          = req[i];
      bus.M_HTRANS[2*i +: 2]  = drv[i];
      bus.M_HADDR[AW*i +: AW] = addr[i];
      bus.M_HWRITE[i]         = wr[i];
      bus.M_HWDATA[DW*i +: DW] = wdat[i];
    end
    bus.HREADY = hready;
  endtask

  task automatic push_exp();
    exp_t e;
    int s = msel();
    e.gnt = 4'(1 << s);
    e.hm  = 2'(s);
    e.tr  = drv[s];
    e.ad  = addr[s];
    e.wr  = wr[s];
    e.wd  = wdat[m_down];
    e.vld = hready && drv[s][1];
    exp_q.push_back(e);
  endtask

  task automatic model_step();
    int s, cnt2, n;
    bit acc, oth, go;
    if (HRESETn || !hready) return;
    s = msel();
    acc = drv[s][1];
    if (acc && !rnd_mode && m_own == bm && bq.size() != 0)
      void'(bq.pop_front());
    m_down = s;
    if (m_own < 0) begin
      n = rr_next();
      if (n >= 0) begin
        m_own = n; m_last = n; m_cnt = 0;
      end
    end else begin
      cnt2 = (acc && m_cnt < TEN) ? m_cnt + 1 : m_cnt;
      oth = 0;
      for (int j = 0; j < NM; j++)
        if (j != m_own && req[j]) oth = 1;
      go = m_drain || !req[m_own] || (cnt2 == TEN && oth);
      if (!go) m_cnt = cnt2;
      else if (drv[m_own] == HT_SEQ) begin
        m_drain = 1; m_cnt = cnt2;
      end else begin
        m_drain = 0; m_cnt = 0;
        n = rr_next();
        m_own = n;
        if (n >= 0) m_last = n;
      end
    end
  endtask

  task automatic step(input bit hr);
    hready = hr;
    drive();
    push_exp();
    model_step();
  endtask

  task automatic cyc(input bit hr);
    @(posedge HCLK); #1;
    step(hr);
  endtask

  // reset lands between edges, released one cycle later
  task automatic async_rst();
    @(posedge HCLK); #2;
    HRESETn = 1'b1;
    model_reset();
    drive();
    push_exp();
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    step(1'b1);
  endtask

  initial begin : mon
    exp_t e, a;
    forever begin
      @(negedge HCLK);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {bus.HGRANT, bus.HMASTER, bus.VALID, bus.HTRANS,
             bus.HADDR, bus.HWRITE, bus.HWDATA};
        n_chk++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL bus_cycle t=%0t got gnt=%b hm=%0d vld=%b tr=%0d ad=%h wr=%b wd=%h exp gnt=%b hm=%0d vld=%b tr=%0d ad=%h wr=%b wd=%h",
            $time, a.gnt, a.hm, a.vld, a.tr, a.ad, a.wr, a.wd,
            e.gnt, e.hm, e.vld, e.tr, e.ad, e.wr, e.wd);
        end
      end
      if (aud_on) begin
        if (int'(bus.HMASTER) != aud_cur) begin
          aud_m.push_back(aud_cur);
          aud_n.push_back(aud_cnt);
          aud_cur = int'(bus.HMASTER);
          aud_cnt = 0;
        end
        if (bus.VALID) aud_cnt++;
      end
    end
  end

  initial begin
    HRESETn = 1'b0;
    for (int i = 0; i < NM; i++) begin
      req[i] = 0; intent[i] = HT_IDLE; rtr[i] = HT_IDLE;
      addr[i] = 32'hA000_0000 + 32'(i * 16);
      wdat[i] = 32'hD0D0_0000 + 32'(i);
      wr[i] = 0;
    end
    addr[2] = 32'h0000_1000;
    model_reset();
    #1 HRESETn = 1'b1;

    @(posedge HCLK); #1;
    drive();
    push_exp();
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    step(1'b1);
    repeat (3) cyc(1'b1);

    // single master from park
    req[2] = 1; intent[2] = HT_NONSEQ; wr[2] = 1;
    repeat (4) cyc(1'b1);
    req[2] = 0; intent[2] = HT_IDLE;
    repeat (3) cyc(1'b1);

    // full contention rotation from a fresh reset
    for (int i = 0; i < NM; i++) begin
      req[i] = 1; intent[i] = HT_NONSEQ;
    end
    async_rst();
    aud_cur = 0; aud_cnt = 0; aud_on = 1;
    repeat (40) cyc(1'b1);
    aud_on = 0;
    for (int k = 0; k < NM; k++) begin
      n_chk++;
      if (k >= aud_m.size()) begin
        n_fail++;
        $display("FAIL tenure_rotation slot=%0d got none required master %0d with %0d beats",
          k, k, TEN);
      end else if (aud_m[k] != k || aud_n[k] != TEN) begin
        n_fail++;
        $display("FAIL tenure_rotation slot=%0d got master %0d beats %0d required master %0d beats %0d",
          k, aud_m[k], aud_n[k], k, TEN);
      end
    end
    for (int i = 0; i < NM; i++) begin
      req[i] = 0; intent[i] = HT_IDLE;
    end
    repeat (3) cyc(1'b1);

    // cap reached mid-burst: drain before handing to M3
    bm = 1;
    bq = {HT_NONSEQ, HT_NONSEQ, HT_NONSEQ, HT_NONSEQ,
          HT_NONSEQ, HT_SEQ, HT_SEQ, HT_SEQ, HT_SEQ,
          HT_SEQ, HT_SEQ, HT_SEQ};
    req[1] = 1;
    cyc(1'b1);
    req[3] = 1; intent[3] = HT_NONSEQ;
    repeat (20) begin
      if (bq.size() == 0) req[1] = 0;
      cyc(1'b1);
    end
    req[3] = 0; intent[3] = HT_IDLE;
    repeat (2) cyc(1'b1);

    // handover M0 -> M2 stretched by HREADY low
    req[0] = 1; intent[0] = HT_NONSEQ; wr[0] = 1;
    repeat (3) cyc(1'b1);
    req[2] = 1; intent[2] = HT_NONSEQ;
    repeat (2) cyc(1'b1);
    req[0] = 0;
    repeat (3) cyc(1'b0);
    cyc(1'b1);
    intent[0] = HT_IDLE;
    repeat (4) cyc(1'b1);

    // random traffic
    rnd_mode = 1;
    repeat (400) begin
      for (int i = 0; i < NM; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = !req[i];
        rtr[i]  = 2'($urandom_range(0, 3));
        addr[i] = $urandom;
        wdat[i] = $urandom;
        wr[i]   = 1'($urandom_range(0, 1));
      end
      cyc($urandom_range(0, 3) != 0);
    end
    rnd_mode = 0;

    // reset in the middle of an M2 burst
    for (int i = 0; i < NM; i++) begin
      req[i] = 0; intent[i] = HT_IDLE;
    end
    bm = 2;
    bq = {HT_NONSEQ, HT_SEQ, HT_SEQ, HT_SEQ,
          HT_SEQ, HT_SEQ, HT_SEQ, HT_SEQ};
    req[2] = 1;
    repeat (8) cyc(1'b1);
    bq.delete();
    for (int i = 0; i < NM; i++) begin
      req[i] = 1; intent[i] = HT_NONSEQ;
    end
    async_rst();
    repeat (4) cyc(1'b1);

    @(negedge HCLK); #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d left required 0",
        exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end
endmodule
